uart_rx_frame: RTL
==================

# uart_rx_frame

Single-clock UART frame receiver: the decoding end of the bit-per-clock serial link driven by the team's UART transmitter. It samples one line bit per `clk` cycle through a two-stage input register, and reassembles start, `DATA_WIDTH` data bits (LSB first), an optional parity bit and `STOP_BITS` stop bits. Each frame is delivered through a one-entry valid/ready output register with parity, framing and overrun status. It sits between the serial pin and the APB-side consumer.

## Interface
- `DATA_WIDTH`, from `shared_pkg` (8): data bits per frame.
- `PARITY_EN`, 0: 0 = no parity bit; 1 = expected parity bit is `~^data`; 2 = expected parity bit is `^data`. This matches the transmitter's encoding exactly.
- `STOP_BITS`, 1: stop bits per frame, legal range 1–3.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line; idle high.
- `rx_data`  out  DATA_WIDTH  received word; valid while `rx_valid` is high.
- `rx_valid`  out  1  a frame is held in the output register.
- `rx_ready`  in  1  consumer accepts the word on a cycle where `rx_valid && rx_ready`.
- `parity_err`  out  1  status of the held frame; parity mismatch. Always 0 when `PARITY_EN==0`.
- `frame_err`  out  1  status of the held frame; at least one stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped because the output register was full.

## Operation
- Input pipeline: `s1 <= rx; rx_s <= s1`. Both stages reset to 1. The FSM uses only `rx_s`.
- FSM states: IDLE, DATA, PARITY, STOP, RECOVER.
- IDLE: when `rx_s==0` (start bit), clear `bit_cnt` and go to DATA. Otherwise stay.
- DATA: shift `rx_s` into `shift_reg` at the MSB end (shift right), so the first bit lands in bit 0. Increment `bit_cnt`. When `bit_cnt==DATA_WIDTH-1`, go to PARITY if `PARITY_EN!=0`, else STOP.
- PARITY: capture `rx_s` and compare it with the expected parity of the assembled word. Latch the mismatch into the frame status. Go to STOP.
- STOP: increment `stop_cnt` each cycle. Any `rx_s==0` in a stop bit sets the frame's framing-error flag. On the last stop bit (`stop_cnt==STOP_BITS-1`):
  - clear `stop_cnt`;
  - deliver the frame;
  - go to IDLE if the last stop bit sampled 1, else go to RECOVER.
- RECOVER: wait until `rx_s==1`, then go to IDLE. This prevents a stuck-low line or break from retriggering frames.
- Delivery on edge D:
  - If `!rx_valid`, or `rx_valid && rx_ready` on D: load `rx_data`, `parity_err`, `frame_err`, and set `rx_valid=1`.
  - Else (output register full and not accepted): discard the new frame, assert `overrun` for one cycle, and leave the held data and status unchanged.
- Frames with parity or framing errors are still delivered, with the flag set.
- Pop: `rx_valid && rx_ready` with no delivery on the same edge clears `rx_valid`. `rx_data` and the status flags keep their last values.
- Default FSM state: IDLE.

## Timing
- Reset values: `rx_valid=0`, `rx_data=0`, `parity_err=0`, `frame_err=0`, `overrun=0`, FSM=IDLE, counters 0, `s1=rx_s=1`.
- Reset asserted mid-frame: the partial frame is abandoned with no delivery and no `overrun`. The held output is cleared.
- Latency: the start bit is sampled by `s1` at edge E0. Data bit i is sampled at E(1+i). `rx_valid` rises at edge E0 + 2 + DATA_WIDTH + P + STOP_BITS, where P = (PARITY_EN!=0).
  - Example: 8N1 gives E11; 8E2 gives E13.
- Back-to-back frames with zero idle cycles are supported: the FSM is in IDLE the cycle after consuming the last stop bit.
- Maximum throughput is one frame per 1 + DATA_WIDTH + P + STOP_BITS cycles. `rx_ready` may be held high permanently.
- `overrun` is coincident with the dropped delivery edge, and is never high for two consecutive cycles unless two deliveries are consecutive (impossible for a legal frame length).

## Test plan
- 8N1, `rx_ready=1`: send 0xA5 with 2 idle cycles before and after -> `rx_data=0xA5` and `rx_valid` high for 1 cycle at E11; both error flags 0.
- PARITY_EN=1, STOP_BITS=2: send 0x3C with parity bit `~^0x3C`=1 -> `parity_err=0`. Resend with parity bit 0 -> `parity_err=1`, `rx_data=0x3C`.
- 8N1: send 0x55, then 0x0F with zero gap, while holding `rx_ready=0` -> 0x55 held; `overrun` pulses once at the second delivery; after `rx_ready=1` for one cycle, `rx_valid=0`.
- 8N1, pop and delivery on the same edge -> `rx_valid` stays 1, new word loaded, `overrun=0`.
- 8N1, stop bit driven 0 and line held low 5 cycles, then high, then a valid 0x81 frame -> first frame delivered with `frame_err=1`; exactly one further frame (0x81, `frame_err=0`); no spurious frames while low.
- Assert `rst` for 1 cycle after data bit 3 of a frame -> all outputs return to reset values, no delivery; the next complete frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: bit-per-clock UART frame receiver with a one-entry
// valid/ready output register and parity/framing/overrun status.

package shared_pkg;
  parameter int unsigned DATA_WIDTH = 8;
endpackage

module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_PARITY  = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  logic                  s1;
  logic                  rx_s;
  logic [2:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [1:0]            stop_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  perr_acc;
  logic                  ferr_acc;
  logic                  exp_par;
  logic                  deliver;
  logic                  frame_ferr;
  logic                  frame_perr;

  // Two-stage input register; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

  // Expected parity of the assembled word and the status of the frame being closed
  always_comb begin
    exp_par    = (PARITY_EN == 2) ? ^shift_reg : ~^shift_reg;
    deliver    = (state == S_STOP) && (stop_cnt == LAST_STOP);
    frame_ferr = ferr_acc | ~rx_s;
    frame_perr = (PARITY_EN != 0) && perr_acc;
  end

  // Frame FSM: start detect, LSB-first data shift, parity, stop bits, break recovery
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      shift_reg <= '0;
      perr_acc  <= 1'b0;
      ferr_acc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            bit_cnt  <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT)
            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          perr_acc <= (rx_s != exp_par);
          state    <= S_STOP;
        end
        S_STOP: begin
          if (!rx_s)
            ferr_acc <= 1'b1;
          if (stop_cnt == LAST_STOP) begin
            stop_cnt <= '0;
            state    <= rx_s ? S_IDLE : S_RECOVER;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          if (rx_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output register: a delivery may replace a word popped on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= frame_perr;
          frame_err  <= frame_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
